dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data memory between two requesters:
  - the core's MEM stage (port C: SW/LW traffic);
  - a loader/debug port (port L), which preloads or inspects data memory without hierarchical pokes.
- Fixed priority to the core, with a starvation guard for the loader and an optional loader burst lock bounded by a timeout.
- Sits between the MEM stage, the loader, and the data memory macro inside the processor top.

---
 rtl/dmem_arbiter_pkg.sv | 25 ++
 rtl/dmem_rsp_tracker.sv | 51 +++++
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared data-memory package: arbiter FSM states, the memory request record
// and the requester port indices used by the arbiter and its response tracker.
package dmem_arbiter_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_L = 1'b1;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Sized by the package widths; the arbiter's ADDR_W/DATA_W must match them.
  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_BE_W-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/dmem_rsp_tracker.sv
// Read response tracker for the data-memory arbiter.
// Remembers that a read was accepted and which port owns it, then steers the
// memory read data (valid one cycle after the strobe) to that port only.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   rd_accept_i         a read was accepted this cycle
//   rd_owner_i          owner of that read (PORT_C / PORT_L)
//   mem_rdata_i         memory read data
//   c_rsp_valid_o/_rdata_o, l_rsp_valid_o/_rdata_o   per-port responses
module dmem_rsp_tracker
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_accept_i,
  input  logic              rd_owner_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              c_rsp_valid_o,
  output logic [DATA_W-1:0] c_rsp_rdata_o,
  output logic              l_rsp_valid_o,
  output logic [DATA_W-1:0] l_rsp_rdata_o
);

  logic rsp_pending_q, rsp_pending_d;
  logic owner_q, owner_d;

  always_comb begin
    rsp_pending_d = rd_accept_i;
    owner_d       = rd_accept_i ? rd_owner_i : owner_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_pending_q <= 1'b0;
      owner_q       <= PORT_C;
    end else begin
      rsp_pending_q <= rsp_pending_d;
      owner_q       <= owner_d;
    end
  end

  // Masking with reset drops a response that would otherwise land in the
  // very cycle reset is being applied.
  assign c_rsp_valid_o = rsp_pending_q && !reset && (owner_q == PORT_C);
  assign l_rsp_valid_o = rsp_pending_q && !reset && (owner_q == PORT_L);
  assign c_rsp_rdata_o = c_rsp_valid_o ? mem_rdata_i : '0;
  assign l_rsp_rdata_o = l_rsp_valid_o ? mem_rdata_i : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port synchronous data memory between
// the core MEM stage (port C) and a loader/debug port (port L).
// Core has fixed priority; a starvation counter forces a loader grant after
// STARVE_MAX lost contended cycles, and the loader may lock the memory for
// back-to-back bursts, bounded by LOCK_MAX cycles.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   c_req_* / c_rsp_*               core request / read response
//   l_req_* / l_rsp_*, l_req_lock   loader request / response / lock hold
//   mem_en, mem_we, mem_addr (word), mem_wdata, mem_be, mem_rdata   memory macro
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                c_req_valid,
  input  logic                c_req_we,
  input  logic [ADDR_W-1:0]   c_req_addr,
  input  logic [DATA_W-1:0]   c_req_wdata,
  input  logic [DATA_W/8-1:0] c_req_be,
  output logic                c_req_ready,
  output logic                c_rsp_valid,
  output logic [DATA_W-1:0]   c_rsp_rdata,
  input  logic                l_req_valid,
  input  logic                l_req_we,
  input  logic [ADDR_W-1:0]   l_req_addr,
  input  logic [DATA_W-1:0]   l_req_wdata,
  input  logic [DATA_W/8-1:0] l_req_be,
  input  logic                l_req_lock,
  output logic                l_req_ready,
  output logic                l_rsp_valid,
  output logic [DATA_W-1:0]   l_rsp_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam int LC_W = $clog2(LOCK_MAX + 1);

  arb_state_t      state_q, state_d;
  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [LC_W-1:0] lock_cnt_q, lock_cnt_d;

  logic     gnt_c, gnt_l;
  logic     starved, lock_expire;
  mem_req_t c_req, l_req, g_req;

  // Memory is word addressed; the byte offset of each request is not needed.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{c_req_addr[1:0], l_req_addr[1:0]};

  assign starved     = (starve_cnt_q == SC_W'(STARVE_MAX));
  assign lock_expire = (lock_cnt_q == LC_W'(LOCK_MAX - 1));

  // Grant: loader owns the memory while locked; otherwise core wins
  // contention unless the loader has been starved long enough.
  always_comb begin
    gnt_c = 1'b0;
    gnt_l = 1'b0;
    if (!reset) begin
      if (state_q == LOCK) begin
        gnt_l = l_req_valid;
      end else if (l_req_valid && (!c_req_valid || starved)) begin
        gnt_l = 1'b1;
      end else begin
        gnt_c = c_req_valid;
      end
    end
  end

  assign c_req_ready = gnt_c;
  assign l_req_ready = gnt_l;

  assign c_req = '{we: c_req_we, addr: c_req_addr, wdata: c_req_wdata, be: c_req_be};
  assign l_req = '{we: l_req_we, addr: l_req_addr, wdata: l_req_wdata, be: l_req_be};
  assign g_req = gnt_l ? l_req : c_req;

  assign mem_en    = gnt_c | gnt_l;
  assign mem_we    = mem_en & g_req.we;
  assign mem_addr  = g_req.addr[ADDR_W-1:2];
  assign mem_wdata = g_req.wdata;
  assign mem_be    = g_req.we ? g_req.be : '1;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    lock_cnt_d   = lock_cnt_q;

    if (!l_req_valid || gnt_l) begin
      starve_cnt_d = '0;
    end else if (!starved) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end

    case (state_q)
      ARB: begin
        if (gnt_l && l_req_lock) begin
          state_d    = LOCK;
          lock_cnt_d = '0;
        end
      end
      LOCK: begin
        lock_cnt_d = lock_cnt_q + LC_W'(1);
        // Timeout also clears starvation so the core wins the next contest.
        if (lock_expire) begin
          state_d      = ARB;
          starve_cnt_d = '0;
        end else if (gnt_l && !l_req_lock) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB;
      starve_cnt_q <= '0;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  dmem_rsp_tracker #(
    .DATA_W (DATA_W)
  ) u_rsp_tracker (
    .clk           (clk),
    .reset         (reset),
    .rd_accept_i   (mem_en & ~mem_we),
    .rd_owner_i    (gnt_l ? PORT_L : PORT_C),
    .mem_rdata_i   (mem_rdata),
    .c_rsp_valid_o (c_rsp_valid),
    .c_rsp_rdata_o (c_rsp_rdata),
    .l_rsp_valid_o (l_rsp_valid),
    .l_rsp_rdata_o (l_rsp_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req_valid, c_req_we, c_req_ready, c_rsp_valid;
  logic [AW-1:0] c_req_addr;
  logic [DW-1:0] c_req_wdata, c_rsp_rdata;
  logic [BW-1:0] c_req_be;
  logic          l_req_valid, l_req_we, l_req_lock, l_req_ready, l_rsp_valid;
  logic [AW-1:0] l_req_addr;
  logic [DW-1:0] l_req_wdata, l_rsp_rdata;
  logic [BW-1:0] l_req_be;
  logic          mem_en, mem_we;
  logic [AW-3:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [BW-1:0] mem_be;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4), .LOCK_MAX(16)) dut (
    .clk(clk), .reset(reset),
    .c_req_valid(c_req_valid), .c_req_we(c_req_we), .c_req_addr(c_req_addr),
    .c_req_wdata(c_req_wdata), .c_req_be(c_req_be), .c_req_ready(c_req_ready),
    .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
    .l_req_valid(l_req_valid), .l_req_we(l_req_we), .l_req_addr(l_req_addr),
    .l_req_wdata(l_req_wdata), .l_req_be(l_req_be), .l_req_lock(l_req_lock),
    .l_req_ready(l_req_ready), .l_rsp_valid(l_rsp_valid), .l_rsp_rdata(l_rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory macro model driven by the DUT.
  logic [31:0] mem [0:255];
  logic        preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) mem[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[7:0]];
      end
    end
  end

  // Reference memory and response scoreboard.
  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  logic [31:0] ref_mem [0:255];
  exp_t        exp_q[$];
  int          vec = 0;
  int          bad = 0;

  task automatic set_c(input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    c_req_valid = v; c_req_we = we; c_req_addr = a; c_req_wdata = d; c_req_be = be;
  endtask

  task automatic set_l(input logic v, input logic we, input logic lk, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    l_req_valid = v; l_req_we = we; l_req_lock = lk; l_req_addr = a; l_req_wdata = d;
    l_req_be = be;
  endtask

  // Records an expected transfer: writes update the reference, reads queue a response.
  task automatic book(input logic port, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a[9:2]][b*8 +: 8] = d[b*8 +: 8];
    end else begin
      exp_q.push_back('{port: port, data: ref_mem[a[9:2]]});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_c(1'b1, 1'b0, 32'h60, 32'h0, 4'hF);
    set_l(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 4'hF);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vec++;
      if ({c_req_ready, l_req_ready, mem_en, c_rsp_valid, l_rsp_valid} !== 5'b0) begin
        bad++;
        $display("FAIL reset_hold: rdy_c/rdy_l/en/rsp_c/rsp_l=%b required 00000",
                 {c_req_ready, l_req_ready, mem_en, c_rsp_valid, l_rsp_valid});
      end
      @(posedge clk); #1;
    end
    preload = 1'b0;
    reset   = 1'b0;
    set_c(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_l(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    vec++;
    if (dut.state_q !== ARB || dut.starve_cnt_q !== '0 || dut.lock_cnt_q !== '0 ||
        c_rsp_valid !== 1'b0 || l_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: state=%0d starve=%0d lock=%0d rsp=%b%b required 0 0 0 00",
               dut.state_q, dut.starve_cnt_q, dut.lock_cnt_q, c_rsp_valid, l_rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_core_only();
    logic v, we; logic [31:0] a, d; logic [3:0] be; exp_t e;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin v = 1; we = 1; a = 32'h60; d = 32'h19; be = 4'hF; end
        1:       begin v = 1; we = 0; a = 32'h60; d = 32'h0;  be = 4'hF; end
        default: begin v = 0; we = 0; a = 32'h0;  d = 32'h0;  be = 4'h0; end
      endcase
      set_c(v, we, a, d, be);
      set_l(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      vec++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if ({c_rsp_valid, l_rsp_valid} !== {~e.port, e.port} ||
            (e.port ? l_rsp_rdata : c_rsp_rdata) !== e.data) begin
          bad++;
          $display("FAIL core_rsp: c=%b/%h l=%b/%h required port %0d data %h",
                   c_rsp_valid, c_rsp_rdata, l_rsp_valid, l_rsp_rdata, e.port, e.data);
        end
      end else if ({c_rsp_valid, l_rsp_valid} !== 2'b00) begin
        bad++;
        $display("FAIL core_rsp_idle: rsp c/l=%b%b required 00", c_rsp_valid, l_rsp_valid);
      end
      vec++;
      if (c_req_ready !== v || l_req_ready !== 1'b0 || mem_en !== v ||
          (v && (mem_we !== we || mem_addr !== a[31:2] || (we && mem_wdata !== d)))) begin
        bad++;
        $display("FAIL core_req k=%0d: rdy=%b en=%b we=%b addr=%h wd=%h required rdy=%b we=%b addr=%h wd=%h",
                 k, c_req_ready, mem_en, mem_we, mem_addr, mem_wdata, v, we, a[31:2], d);
      end
      if (v) book(PORT_C, we, a, d, be);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_byte_enables();
    logic v, we; logic [31:0] a, d; logic [3:0] be; exp_t e;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       begin v = 1; we = 1; a = 32'h40; d = 32'h11223344; be = 4'hF; end
        1:       begin v = 1; we = 1; a = 32'h40; d = 32'hDEADBEEF; be = 4'b0011; end
        2:       begin v = 1; we = 0; a = 32'h40; d = 32'h0;        be = 4'b0011; end
        default: begin v = 0; we = 0; a = 32'h0;  d = 32'h0;        be = 4'h0; end
      endcase
      set_c(v, we, a, d, be);
      @(negedge clk);
      vec++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if ({c_rsp_valid, l_rsp_valid} !== {~e.port, e.port} ||
            (e.port ? l_rsp_rdata : c_rsp_rdata) !== e.data) begin
          bad++;
          $display("FAIL be_rsp: c=%b/%h l=%b/%h required port %0d data %h",
                   c_rsp_valid, c_rsp_rdata, l_rsp_valid, l_rsp_rdata, e.port, e.data);
        end
      end else if ({c_rsp_valid, l_rsp_valid} !== 2'b00) begin
        bad++;
        $display("FAIL be_rsp_idle: rsp c/l=%b%b required 00", c_rsp_valid, l_rsp_valid);
      end
      if (v) begin
        vec++;
        if (c_req_ready !== 1'b1 || mem_we !== we || mem_be !== (we ? be : 4'hF)) begin
          bad++;
          $display("FAIL be_strobe k=%0d: rdy=%b we=%b be=%b required 1 %b %b",
                   k, c_req_ready, mem_we, mem_be, we, we ? be : 4'hF);
        end
        book(PORT_C, we, a, d, be);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lock();
    logic exp_l, cv; logic lk, lv; logic [31:0] la; exp_t e;
    for (int k = 0; k < 6; k++) begin
      lv = (k < 4); lk = (k < 3); la = 32'(k * 4);
      cv = (k >= 1 && k <= 4);
      exp_l = lv;
      set_l(lv, 1'b1, lk, la, 32'hA5A5A5A5, 4'hF);
      set_c(cv, 1'b0, 32'h60, 32'h0, 4'hF);
      @(negedge clk);
      vec++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if ({c_rsp_valid, l_rsp_valid} !== {~e.port, e.port} ||
            (e.port ? l_rsp_rdata : c_rsp_rdata) !== e.data) begin
          bad++;
          $display("FAIL lock_rsp: c=%b/%h l=%b/%h required port %0d data %h",
                   c_rsp_valid, c_rsp_rdata, l_rsp_valid, l_rsp_rdata, e.port, e.data);
        end
      end else if ({c_rsp_valid, l_rsp_valid} !== 2'b00) begin
        bad++;
        $display("FAIL lock_rsp_idle: rsp c/l=%b%b required 00", c_rsp_valid, l_rsp_valid);
      end
      vec++;
      if ({c_req_ready, l_req_ready} !== {cv & ~exp_l, exp_l} ||
          (exp_l && (mem_we !== 1'b1 || mem_addr !== la[31:2] || mem_wdata !== 32'hA5A5A5A5))) begin
        bad++;
        $display("FAIL lock_grant k=%0d: rdy c/l=%b%b we=%b addr=%h wd=%h required rdy %b%b",
                 k, c_req_ready, l_req_ready, mem_we, mem_addr, mem_wdata, cv & ~exp_l, exp_l);
      end
      if (exp_l) book(PORT_L, 1'b1, la, 32'hA5A5A5A5, 4'hF);
      else if (cv) book(PORT_C, 1'b0, 32'h60, 32'h0, 4'hF);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_contention();
    int nc = 0, nl = 0; logic exp_l, act; logic [31:0] ca, la; exp_t e;
    for (int k = 0; k < 11; k++) begin
      act = (k < 10);
      ca = 32'(nc * 4); la = 32'h100 + 32'(nl * 4);
      exp_l = (k % 5 == 4);
      set_c(act, 1'b0, ca, 32'h0, 4'hF);
      set_l(act, 1'b0, 1'b0, la, 32'h0, 4'hF);
      @(negedge clk);
      vec++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if ({c_rsp_valid, l_rsp_valid} !== {~e.port, e.port} ||
            (e.port ? l_rsp_rdata : c_rsp_rdata) !== e.data) begin
          bad++;
          $display("FAIL cont_rsp k=%0d: c=%b/%h l=%b/%h required port %0d data %h",
                   k, c_rsp_valid, c_rsp_rdata, l_rsp_valid, l_rsp_rdata, e.port, e.data);
        end
      end else if ({c_rsp_valid, l_rsp_valid} !== 2'b00) begin
        bad++;
        $display("FAIL cont_rsp_idle: rsp c/l=%b%b required 00", c_rsp_valid, l_rsp_valid);
      end
      if (act) begin
        vec++;
        if ({c_req_ready, l_req_ready} !== {~exp_l, exp_l} ||
            mem_addr !== (exp_l ? la[31:2] : ca[31:2])) begin
          bad++;
          $display("FAIL cont_grant k=%0d: rdy c/l=%b%b addr=%h required %b%b addr=%h",
                   k, c_req_ready, l_req_ready, mem_addr, ~exp_l, exp_l,
                   exp_l ? la[31:2] : ca[31:2]);
        end
        if (exp_l) begin book(PORT_L, 1'b0, la, 32'h0, 4'hF); nl++; end
        else       begin book(PORT_C, 1'b0, ca, 32'h0, 4'hF); nc++; end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lock_timeout();
    logic lv, cv, exp_c; exp_t e;
    for (int k = 0; k < 22; k++) begin
      lv = (k <= 20); cv = (k >= 1 && k <= 17);
      exp_c = (k == 17);
      set_l(lv, 1'b0, (k != 20), 32'h100, 32'h0, 4'hF);
      set_c(cv, 1'b0, 32'h60, 32'h0, 4'hF);
      @(negedge clk);
      vec++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if ({c_rsp_valid, l_rsp_valid} !== {~e.port, e.port} ||
            (e.port ? l_rsp_rdata : c_rsp_rdata) !== e.data) begin
          bad++;
          $display("FAIL tmo_rsp k=%0d: c=%b/%h l=%b/%h required port %0d data %h",
                   k, c_rsp_valid, c_rsp_rdata, l_rsp_valid, l_rsp_rdata, e.port, e.data);
        end
      end else if ({c_rsp_valid, l_rsp_valid} !== 2'b00) begin
        bad++;
        $display("FAIL tmo_rsp_idle: rsp c/l=%b%b required 00", c_rsp_valid, l_rsp_valid);
      end
      if (lv) begin
        vec++;
        if ({c_req_ready, l_req_ready} !== {exp_c, ~exp_c}) begin
          bad++;
          $display("FAIL tmo_grant k=%0d: rdy c/l=%b%b required %b%b",
                   k, c_req_ready, l_req_ready, exp_c, ~exp_c);
        end
        if (exp_c) book(PORT_C, 1'b0, 32'h60, 32'h0, 4'hF);
        else       book(PORT_L, 1'b0, 32'h100, 32'h0, 4'hF);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midop();
    exp_t e;
    // Enter LOCK with a write, then an accepted loader read.
    set_c(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_l(1'b1, 1'b1, 1'b1, 32'h200, 32'h5A5A5A5A, 4'hF);
    @(negedge clk);
    vec++;
    if (l_req_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_lock_wr: l_rdy=%b required 1", l_req_ready);
    end
    book(PORT_L, 1'b1, 32'h200, 32'h5A5A5A5A, 4'hF);
    @(posedge clk); #1;
    set_l(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 4'hF);
    @(negedge clk);
    vec++;
    if (l_req_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL midrst_rd: l_rdy=%b en=%b we=%b required 1 1 0", l_req_ready, mem_en, mem_we);
    end
    book(PORT_L, 1'b0, 32'h100, 32'h0, 4'hF);
    @(posedge clk); #1;
    // Reset the cycle after the accepted read: its response must be dropped.
    reset = 1'b1;
    exp_q.delete();
    set_c(1'b1, 1'b0, 32'h60, 32'h0, 4'hF);
    set_l(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 4'hF);
    @(negedge clk);
    vec++;
    if ({c_rsp_valid, l_rsp_valid, c_req_ready, l_req_ready, mem_en} !== 5'b0) begin
      bad++;
      $display("FAIL midrst_drop: rsp c/l rdy c/l en=%b required 00000",
               {c_rsp_valid, l_rsp_valid, c_req_ready, l_req_ready, mem_en});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    set_l(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    vec++;
    if (dut.state_q !== ARB || dut.starve_cnt_q !== '0 || dut.lock_cnt_q !== '0 ||
        c_rsp_valid !== 1'b0 || l_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state: state=%0d starve=%0d lock=%0d rsp=%b%b required 0 0 0 00",
               dut.state_q, dut.starve_cnt_q, dut.lock_cnt_q, c_rsp_valid, l_rsp_valid);
    end
    vec++;
    if (c_req_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_first_req: c_rdy=%b required 1", c_req_ready);
    end
    book(PORT_C, 1'b0, 32'h60, 32'h0, 4'hF);
    @(posedge clk); #1;
    set_c(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    vec++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if ({c_rsp_valid, l_rsp_valid} !== {~e.port, e.port} || c_rsp_rdata !== e.data) begin
        bad++;
        $display("FAIL midrst_rsp: c=%b/%h l=%b required port %0d data %h",
                 c_rsp_valid, c_rsp_rdata, l_rsp_valid, e.port, e.data);
      end
    end else begin
      bad++; $display("FAIL midrst_rsp: no expected entry queued, required one");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
    l_req_lock = 1'b0;
    test_reset();
    test_core_only();
    test_byte_enables();
    test_lock();
    test_contention();
    test_lock_timeout();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
